// File: rtl/alu_sequencer_if.sv
// Decode-side request and consumer-side response channels of the ALU sequencer.
interface alu_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int FLAG_W = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   in_op;
  logic [DATA_W-1:0] in_src;
  logic [DATA_W-1:0] in_dst;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic [FLAG_W-1:0] out_flags;
  logic              branch_taken;
  logic [DATA_W-1:0] branch_target;

  modport master (
    output in_valid, in_op, in_src, in_dst, out_ready,
    input  in_ready, out_valid, out_result, out_flags, branch_taken, branch_target
  );

  modport slave (
    input  in_valid, in_op, in_src, in_dst, out_ready,
    output in_ready, out_valid, out_result, out_flags, branch_taken, branch_target
  );
endinterface

// File: rtl/alu_sequencer.sv
// Issue controller for a registered ALU: one op in flight, branch resolution,
// carry fix-up ops, and interrupt carry save/restore built from SETC/CLRC.
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 5,
  parameter int FLAG_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  alu_sequencer_if.slave    bus,
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_src,
  output logic [DATA_W-1:0] alu_dst,
  output logic              alu_reset,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              irq,
  output logic              irq_ack,
  output logic              in_service
);
  localparam logic [OP_W-1:0] OP_NOP  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_SETC = OP_W'(1);
  localparam logic [OP_W-1:0] OP_CLRC = OP_W'(2);
  localparam logic [OP_W-1:0] OP_JZ   = OP_W'(20);
  localparam logic [OP_W-1:0] OP_JN   = OP_W'(21);
  localparam logic [OP_W-1:0] OP_JC   = OP_W'(22);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(23);
  localparam logic [OP_W-1:0] OP_RETI = OP_W'(26);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_FIXUP, S_RESP} state_t;

  state_t            state, state_nx;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] src_q, dst_q, res_q;
  logic [FLAG_W-1:0] flags_q;
  logic              saved_carry;  // only carry is ever restored on RETI
  logic              taken_q;
  logic [1:0]        rst_sr;
  logic              resp_valid, idle_ready, irq_take, taken, fixup_need, fix_carry;

  // Shift register holds the ALU in reset for two edges after release.
  assign alu_reset  = ~rst_sr[1];
  assign irq_take   = (state == S_IDLE) & irq & ~in_service;
  assign idle_ready = ~alu_reset & ~(irq & ~in_service);
  assign taken      = ((op_q == OP_JZ) & alu_flags[1]) | ((op_q == OP_JN) & alu_flags[2]) |
                      ((op_q == OP_JC) & alu_flags[0]) |  (op_q == OP_JMP);
  assign fixup_need = ((op_q == OP_JC) & taken) | ((op_q == OP_RETI) & in_service);
  assign fix_carry  = (op_q == OP_RETI) & saved_carry;

  assign alu_src            = src_q;
  assign alu_dst            = dst_q;
  assign bus.out_valid      = resp_valid;
  assign bus.out_result     = res_q;
  assign bus.out_flags      = flags_q;
  assign bus.branch_taken   = resp_valid & taken_q;
  assign bus.branch_target  = res_q;

  // NOTE: every state element uses <= so all registers sample pre-edge values together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      rst_sr      <= 2'b00;
      op_q        <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      res_q       <= '0;
      flags_q     <= '0;
      saved_carry <= 1'b0;
      taken_q     <= 1'b0;
      in_service  <= 1'b0;
    end else begin
      state  <= state_nx;
      rst_sr <= {rst_sr[0], 1'b1};
      case (state)
        S_IDLE: begin
          if (irq_take) begin
            saved_carry <= alu_flags[0];
            in_service  <= 1'b1;
          end else if (bus.in_valid && idle_ready) begin
            op_q  <= bus.in_op;
            src_q <= bus.in_src;
            dst_q <= bus.in_dst;
          end
        end
        S_WAIT: begin
          res_q   <= alu_result;
          flags_q <= alu_flags;
          taken_q <= taken;
        end
        S_FIXUP: begin
          flags_q[0] <= fix_carry;
          if (op_q == OP_RETI) in_service <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: defaults first so no path through the case leaves an output unassigned (no latches).
  always_comb begin
    state_nx     = state;
    alu_control  = OP_NOP;
    bus.in_ready = 1'b0;
    resp_valid   = 1'b0;
    irq_ack      = 1'b0;
    case (state)
      S_IDLE: begin
        bus.in_ready = idle_ready;
        irq_ack      = irq_take;
        if (!irq_take && bus.in_valid && idle_ready) state_nx = S_ISSUE;
      end
      S_ISSUE: begin
        alu_control = op_q;
        state_nx    = S_WAIT;
      end
      S_WAIT:  state_nx = fixup_need ? S_FIXUP : S_RESP;
      S_FIXUP: begin
        alu_control = fix_carry ? OP_SETC : OP_CLRC;
        state_nx    = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (bus.out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Issue controller between the decode stage and the registered ALU (alu_control codes 0-26, flags {V,N,Z,C} = bits 3..0).
- Accepts one decoded operation at a time over a valid/ready handshake and drives the ALU for one issue cycle.
- Captures the result and flags, resolves JZ/JN/JC/JMP, and inserts the CLRC/SETC fix-up ops that carry handling needs.
- Sequences interrupt entry (flag save) and RETI (carry restore) using only existing ALU ops.

Parameters:
DATA_W, 16, operand/result width
OP_W, 5, alu_control width
FLAG_W, 4, flags width (0 carry, 1 zero, 2 negative, 3 overflow)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  decoded op available
in_ready  out  1  sequencer accepts op this cycle
in_op  in  OP_W  alu_control code
in_src  in  DATA_W  source operand
in_dst  in  DATA_W  destination operand / immediate / jump target
alu_control  out  OP_W  to ALU
alu_src  out  DATA_W  to ALU
alu_dst  out  DATA_W  to ALU
alu_reset  out  1  active-high synchronous reset to ALU
alu_result  in  DATA_W  from ALU (registered)
alu_flags  in  FLAG_W  from ALU (registered)
out_valid  out  1  response available
out_ready  in  1  consumer takes response
out_result  out  DATA_W  captured ALU result
out_flags  out  FLAG_W  flags after op, including any fix-up
branch_taken  out  1  valid with out_valid; jump resolved taken
branch_target  out  DATA_W  jump target (captured result)
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle pulse, interrupt accepted
in_service  out  1  interrupt handler active

Behaviour:
- Reset low (async):
  - state=IDLE; all outputs 0, except alu_reset=1 and alu_control=0 (NOP).
  - op_q/src_q/dst_q/res_q/flags_q/saved_flags cleared; in_service=0.
- After reset release: alu_reset deasserts on the 2nd rising edge, so the ALU sees at least one reset edge. in_ready=0 while alu_reset=1.
- alu_control=0 in every state except ISSUE and FIXUP. alu_src/alu_dst are driven from src_q/dst_q at all times.
- IDLE:
  - in_ready = ~alu_reset & ~(irq & ~in_service).
  - If irq & ~in_service (priority over in_valid): saved_flags<=alu_flags, in_service<=1, irq_ack=1 for that cycle, stay IDLE.
  - Else if in_valid & in_ready: latch in_op/in_src/in_dst, go to ISSUE.
- ISSUE: alu_control=op_q; ALU computes at this edge; go to WAIT.
- WAIT: res_q<=alu_result; flags_q<=alu_flags; evaluate branch.
  - taken = (op 20 & Z) | (op 21 & N) | (op 22 & C) | (op 23).
  - Next state FIXUP if (op 22 & taken) or (op 26 & in_service); else RESP.
- FIXUP:
  - JC taken: alu_control=2 (CLRC).
  - RETI in service: alu_control = saved_flags[0] ? 1 (SETC) : 2 (CLRC).
  - flags_q[0] is updated to the same value; in_service<=0 for RETI. Go to RESP.
- RESP: out_valid=1, out_result=res_q, out_flags=flags_q, branch_taken=taken_q, branch_target=res_q. Stay until out_ready, then go to IDLE. Outputs are stable while stalled.
- Latency (handshake at edge 0): out_valid rises after edge 2; after edge 3 with FIXUP. Maximum throughput is one op per 4 cycles (5 with FIXUP).
- branch_taken=0 for all op codes outside 20-23.
- RETI with in_service=0 behaves as a plain op: no fix-up, flags untouched.
- irq while busy is ignored until IDLE. irq while in_service=1 is masked.
- RETI restores only carry; Z/N/V keep their live ALU values.
- Reset mid-operation aborts at once: the pending response is dropped and the ALU is reset via alu_reset.
- in_op codes 27-31 pass through the ISSUE/WAIT/RESP path (the ALU ignores them) with branch_taken=0.

Test Plan:
- Reset then ADD (9), src=0x7FFF, dst=0x0001, out_ready=1 -> alu_reset high for 2 edges; out_valid 3 cycles after accept; out_result=0x8000, out_flags=0b1100, branch_taken=0.
- SETC, then JC with dst=0x0040 -> FIXUP issues alu_control=2; out_valid 4 cycles after accept; branch_taken=1, branch_target=0x0040, out_flags[0]=0; next op sees C=0.
- JZ with Z=0 (after INC of 0x0000) -> branch_taken=0, no FIXUP, latency 3.
- irq asserted in IDLE with C=1 -> irq_ack one cycle, in_service=1, in_ready=0 that cycle; CLRC; RETI -> FIXUP issues SETC, C=1, in_service=0.
- irq pulse while in_service=1, or during ISSUE -> no irq_ack until IDLE and not in service.
- out_ready held low 5 cycles in RESP -> out_valid and outputs stable, in_ready=0; reset pulled low in RESP -> out_valid=0 immediately, state IDLE.
